// File: rtl/nn_job_scheduler_pkg.sv
// Shared types and defaults for the MLP job scheduler.
// Holds the FSM state encoding and the default sizing constants.
package nn_job_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TR_ISSUE,
    ST_TR_WAIT,
    ST_IN_ISSUE,
    ST_IN_WAIT
  } state_e;

  localparam int N_EPOCHS_DEF  = 20;
  localparam int N_SAMPLES_DEF = 20;
  localparam int EPOCH_W_DEF   = 8;
  localparam int SAMPLE_W_DEF  = 5;
  localparam int PROB_W_DEF    = 7;
  localparam int TIMEOUT_DEF   = 65535;

endpackage

// File: rtl/nn_job_scheduler.sv
// Arbitrates the shared MLP engine between training runs and single inferences.
// It tracks training progress, latches the inference result and guards against engine hangs.
module nn_job_scheduler
  import nn_job_scheduler_pkg::*;
#(
  parameter int N_EPOCHS  = N_EPOCHS_DEF,
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int EPOCH_W   = EPOCH_W_DEF,
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int PROB_W    = PROB_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                train_req,
  input  logic                infer_req,
  input  logic [15:0]         infer_pattern,
  output logic                eng_start,
  output logic                eng_train,
  output logic [SAMPLE_W-1:0] eng_sample_idx,
  output logic [15:0]         eng_pattern,
  input  logic                eng_done,
  input  logic                eng_y,
  input  logic [PROB_W-1:0]   eng_prob,
  output logic                training_active,
  output logic                training_done,
  output logic [EPOCH_W-1:0]  current_epoch,
  output logic [SAMPLE_W-1:0] current_sample,
  output logic                result_valid,
  output logic                result_y,
  output logic [PROB_W-1:0]   result_prob,
  output logic                timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [SAMPLE_W-1:0] LAST_S = SAMPLE_W'(N_SAMPLES - 1);
  localparam logic [EPOCH_W-1:0] LAST_E = EPOCH_W'(N_EPOCHS - 1);
  localparam logic [WD_W-1:0] LAST_WD = WD_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                prev_tr_q, prev_tr_d;
  logic                prev_in_q, prev_in_d;
  logic                pend_q, pend_d;
  logic                start_q, start_d;
  logic                mode_q, mode_d;
  logic [15:0]         pat_q, pat_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                active_q, active_d;
  logic                done_q, done_d;
  logic                rv_q, rv_d;
  logic                ry_q, ry_d;
  logic [PROB_W-1:0]   rp_q, rp_d;
  logic                terr_q, terr_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                tr_edge, in_edge;

  always_comb begin
    tr_edge   = train_req & ~prev_tr_q;
    in_edge   = infer_req & ~prev_in_q;
    state_d   = state_q;
    prev_tr_d = train_req;
    prev_in_d = infer_req;
    pend_d    = pend_q;
    start_d   = 1'b0;
    mode_d    = mode_q;
    pat_d     = pat_q;
    epoch_d   = epoch_q;
    sample_d  = sample_q;
    active_d  = active_q;
    done_d    = done_q;
    rv_d      = rv_q;
    ry_d      = ry_q;
    rp_d      = rp_q;
    terr_d    = terr_q;
    wd_d      = wd_q;
    unique case (state_q)
      ST_IDLE: begin
        // A train queued during inference outranks any fresh infer edge.
        if (tr_edge || pend_q) begin
          state_d  = ST_TR_ISSUE;
          pend_d   = 1'b0;
          start_d  = 1'b1;
          mode_d   = 1'b1;
          epoch_d  = '0;
          sample_d = '0;
          done_d   = 1'b0;
          rv_d     = 1'b0;
          terr_d   = 1'b0;
          active_d = 1'b1;
        end else if (in_edge) begin
          state_d = ST_IN_ISSUE;
          start_d = 1'b1;
          mode_d  = 1'b0;
          pat_d   = infer_pattern;
          rv_d    = 1'b0;
        end
      end
      ST_TR_ISSUE, ST_IN_ISSUE: begin
        state_d = (state_q == ST_TR_ISSUE) ? ST_TR_WAIT : ST_IN_WAIT;
        wd_d    = '0;
        if (state_q == ST_IN_ISSUE && tr_edge) pend_d = 1'b1;
      end
      ST_TR_WAIT: begin
        if (eng_done) begin
          if (sample_q == LAST_S) begin
            sample_d = '0;
            if (epoch_q == LAST_E) begin
              state_d  = ST_IDLE;
              active_d = 1'b0;
              done_d   = 1'b1;
            end else begin
              epoch_d = epoch_q + 1'b1;
              state_d = ST_TR_ISSUE;
              start_d = 1'b1;
            end
          end else begin
            sample_d = sample_q + 1'b1;
            state_d  = ST_TR_ISSUE;
            start_d  = 1'b1;
          end
        end else if (wd_q == LAST_WD) begin
          state_d  = ST_IDLE;
          terr_d   = 1'b1;
          active_d = 1'b0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_IN_WAIT: begin
        if (tr_edge) pend_d = 1'b1;
        if (eng_done) begin
          state_d = ST_IDLE;
          ry_d    = eng_y;
          rp_d    = eng_prob;
          rv_d    = 1'b1;
        end else if (wd_q == LAST_WD) begin
          state_d = ST_IDLE;
          terr_d  = 1'b1;
          pend_d  = 1'b0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prev_tr_q <= 1'b0;
      prev_in_q <= 1'b0;
      pend_q    <= 1'b0;
      start_q   <= 1'b0;
      mode_q    <= 1'b0;
      pat_q     <= '0;
      epoch_q   <= '0;
      sample_q  <= '0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      rv_q      <= 1'b0;
      ry_q      <= 1'b0;
      rp_q      <= '0;
      terr_q    <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      prev_tr_q <= prev_tr_d;
      prev_in_q <= prev_in_d;
      pend_q    <= pend_d;
      start_q   <= start_d;
      mode_q    <= mode_d;
      pat_q     <= pat_d;
      epoch_q   <= epoch_d;
      sample_q  <= sample_d;
      active_q  <= active_d;
      done_q    <= done_d;
      rv_q      <= rv_d;
      ry_q      <= ry_d;
      rp_q      <= rp_d;
      terr_q    <= terr_d;
      wd_q      <= wd_d;
    end
  end

  assign eng_start       = start_q;
  assign eng_train       = mode_q;
  assign eng_sample_idx  = sample_q;
  assign eng_pattern     = pat_q;
  assign training_active = active_q;
  assign training_done   = done_q;
  assign current_epoch   = epoch_q;
  assign current_sample  = sample_q;
  assign result_valid    = rv_q;
  assign result_y        = ry_q;
  assign result_prob     = rp_q;
  assign timeout_err     = terr_q;

endmodule

// File: tb/tb_nn_job_scheduler.sv
// Directed bench for nn_job_scheduler with a 3-cycle engine responder.
// Short watchdog (100 cycles) keeps the hang scenarios brief.
module tb_nn_job_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        train_req = 1'b0;
  logic        infer_req = 1'b0;
  logic [15:0] infer_pattern = '0;
  logic        eng_start, eng_train;
  logic [4:0]  eng_sample_idx;
  logic [15:0] eng_pattern;
  logic        eng_done = 1'b0;
  logic        eng_y = 1'b0;
  logic [6:0]  eng_prob = '0;
  logic        training_active, training_done;
  logic [7:0]  current_epoch;
  logic [4:0]  current_sample;
  logic        result_valid, result_y;
  logic [6:0]  result_prob;
  logic        timeout_err;
  logic [47:0] outs;

  int checks = 0;
  int errors = 0;

  logic       eng_en = 1'b1;
  logic       ey = 1'b0;
  logic [6:0] ep = '0;
  int         cnt = 0;
  int         n_log = 0;
  bit         log_train [0:1023];
  logic [4:0] log_idx [0:1023];

  nn_job_scheduler #(.TIMEOUT(100)) dut (
    .clk(clk), .rst(rst),
    .train_req(train_req), .infer_req(infer_req),
    .infer_pattern(infer_pattern),
    .eng_start(eng_start), .eng_train(eng_train),
    .eng_sample_idx(eng_sample_idx), .eng_pattern(eng_pattern),
    .eng_done(eng_done), .eng_y(eng_y), .eng_prob(eng_prob),
    .training_active(training_active), .training_done(training_done),
    .current_epoch(current_epoch), .current_sample(current_sample),
    .result_valid(result_valid), .result_y(result_y),
    .result_prob(result_prob), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign outs = {eng_start, eng_train, eng_sample_idx, eng_pattern,
                 training_active, training_done, current_epoch,
                 current_sample, result_valid, result_y, result_prob,
                 timeout_err};

  // Engine model and job logger: done pulses 3 cycles after start.
  always @(negedge clk) begin
    eng_done = 1'b0;
    if (rst) begin
      cnt = 0;
    end else if (eng_start) begin
      if (n_log < 1024) begin
        log_train[n_log] = eng_train;
        log_idx[n_log]   = eng_sample_idx;
      end
      n_log++;
      if (eng_en) cnt = 3;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        eng_done = 1'b1;
        eng_y    = ey;
        eng_prob = ep;
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outs: got %h expected 0", outs);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL idle_outs: got %h expected 0", outs);
    end
  endtask

  task automatic test_train_full();
    n_log = 0;
    @(negedge clk) train_req = 1'b1;
    @(negedge clk);
    checks++;
    if (eng_start !== 1'b1 || training_active !== 1'b1) begin
      errors++;
      $display("FAIL train_issue: start=%b active=%b expected 1 1",
               eng_start, training_active);
    end
    checks++;
    if (current_epoch !== 8'd0) begin
      errors++;
      $display("FAIL train_epoch0: got %0d expected 0", current_epoch);
    end
    repeat (98) @(negedge clk);
    train_req = 1'b0;
    for (int i = 0; i < 3000 && !training_done; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (training_done !== 1'b1 || training_active !== 1'b0) begin
      errors++;
      $display("FAIL train_end: done=%b active=%b expected 1 0",
               training_done, training_active);
    end
    checks++;
    if (current_epoch !== 8'd19 || current_sample !== 5'd0) begin
      errors++;
      $display("FAIL train_counters: epoch=%0d sample=%0d expected 19 0",
               current_epoch, current_sample);
    end
    checks++;
    if (n_log !== 400) begin
      errors++;
      $display("FAIL train_jobs: got %0d expected 400", n_log);
    end
    for (int i = 0; i < 400; i++) begin
      checks++;
      if (log_train[i] !== 1'b1 || log_idx[i] !== 5'(i % 20)) begin
        errors++;
        $display("FAIL train_job[%0d]: train=%b idx=%0d expected 1 %0d",
                 i, log_train[i], log_idx[i], i % 20);
      end
    end
  endtask

  task automatic test_infer();
    logic [15:0] pats [3];
    logic        ys [3];
    logic [6:0]  ps [3];
    pats = '{16'h7D9F, 16'h0000, 16'hFFFF};
    ys   = '{1'b1, 1'b0, 1'b1};
    ps   = '{7'd92, 7'd7, 7'd100};
    for (int v = 0; v < 3; v++) begin
      ey = ys[v];
      ep = ps[v];
      n_log = 0;
      @(negedge clk);
      infer_pattern = pats[v];
      infer_req = 1'b1;
      @(negedge clk);
      infer_pattern = ~pats[v];
      checks++;
      if (eng_start !== 1'b1 || eng_train !== 1'b0 || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL infer_issue[%0d]: start=%b train=%b rv=%b expected 1 0 0",
                 v, eng_start, eng_train, result_valid);
      end
      for (int i = 0; i < 20 && !result_valid; i++) begin
        checks++;
        if (eng_pattern !== pats[v]) begin
          errors++;
          $display("FAIL infer_pattern[%0d]: got %h expected %h",
                   v, eng_pattern, pats[v]);
        end
        @(negedge clk);
      end
      checks++;
      if (result_valid !== 1'b1 || result_y !== ys[v] || result_prob !== ps[v]) begin
        errors++;
        $display("FAIL infer_result[%0d]: rv=%b y=%b p=%0d expected 1 %b %0d",
                 v, result_valid, result_y, result_prob, ys[v], ps[v]);
      end
      checks++;
      if (n_log !== 1) begin
        errors++;
        $display("FAIL infer_jobs[%0d]: got %0d expected 1", v, n_log);
      end
      infer_req = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_simultaneous();
    int n_inf;
    n_log = 0;
    @(negedge clk);
    train_req = 1'b1;
    infer_req = 1'b1;
    @(negedge clk);
    checks++;
    if (eng_start !== 1'b1 || eng_train !== 1'b1) begin
      errors++;
      $display("FAIL simul_issue: start=%b train=%b expected 1 1",
               eng_start, eng_train);
    end
    checks++;
    if (training_done !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_clear: done=%b rv=%b expected 0 0",
               training_done, result_valid);
    end
    repeat (5) @(negedge clk);
    train_req = 1'b0;
    infer_req = 1'b0;
    for (int i = 0; i < 3000 && !training_done; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    n_inf = 0;
    for (int i = 0; i < n_log && i < 1024; i++) if (!log_train[i]) n_inf++;
    checks++;
    if (n_log !== 400 || n_inf !== 0) begin
      errors++;
      $display("FAIL simul_jobs: total=%0d infer=%0d expected 400 0", n_log, n_inf);
    end
    checks++;
    if (training_done !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_end: done=%b rv=%b expected 1 0",
               training_done, result_valid);
    end
  endtask

  task automatic test_busy_requests();
    int n_inf;
    n_log = 0;
    @(negedge clk) train_req = 1'b1;
    repeat (2) @(negedge clk);
    train_req = 1'b0;
    for (int i = 0; i < 2000 && current_epoch != 8'd5; i++) @(negedge clk);
    @(negedge clk);
    infer_req = 1'b1;
    train_req = 1'b1;
    repeat (3) @(negedge clk);
    infer_req = 1'b0;
    train_req = 1'b0;
    checks++;
    if (current_epoch !== 8'd5 || training_active !== 1'b1) begin
      errors++;
      $display("FAIL busy_norestart: epoch=%0d active=%b expected 5 1",
               current_epoch, training_active);
    end
    for (int i = 0; i < 3000 && !training_done; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    n_inf = 0;
    for (int i = 0; i < n_log && i < 1024; i++) if (!log_train[i]) n_inf++;
    checks++;
    if (n_log !== 400 || n_inf !== 0 || training_done !== 1'b1) begin
      errors++;
      $display("FAIL busy_jobs: total=%0d infer=%0d done=%b expected 400 0 1",
               n_log, n_inf, training_done);
    end
    ey = 1'b0;
    ep = 7'd33;
    @(negedge clk);
    infer_pattern = 16'hA5A5;
    infer_req = 1'b1;
    for (int i = 0; i < 5 && !eng_start; i++) @(negedge clk);
    @(negedge clk) train_req = 1'b1;
    for (int i = 0; i < 10 && !result_valid; i++) @(negedge clk);
    checks++;
    if (result_valid !== 1'b1 || result_y !== 1'b0 || result_prob !== 7'd33) begin
      errors++;
      $display("FAIL pend_infer: rv=%b y=%b p=%0d expected 1 0 33",
               result_valid, result_y, result_prob);
    end
    checks++;
    if (eng_start !== 1'b0 || training_active !== 1'b0) begin
      errors++;
      $display("FAIL pend_wait: start=%b active=%b expected 0 0",
               eng_start, training_active);
    end
    @(negedge clk);
    checks++;
    if (eng_start !== 1'b1 || eng_train !== 1'b1 || training_active !== 1'b1) begin
      errors++;
      $display("FAIL pend_train: start=%b train=%b active=%b expected 1 1 1",
               eng_start, eng_train, training_active);
    end
    checks++;
    if (eng_sample_idx !== 5'd0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL pend_clear: idx=%0d rv=%b expected 0 0",
               eng_sample_idx, result_valid);
    end
    infer_req = 1'b0;
    train_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2000 && current_epoch != 8'd10; i++) @(negedge clk);
    checks++;
    if (current_epoch !== 8'd10) begin
      errors++;
      $display("FAIL mid_reach: epoch=%0d expected 10", current_epoch);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", outs);
    end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    n_log = 0;
    @(negedge clk) train_req = 1'b1;
    @(negedge clk);
    checks++;
    if (eng_start !== 1'b1 || eng_sample_idx !== 5'd0 ||
        current_epoch !== 8'd0 || training_active !== 1'b1) begin
      errors++;
      $display("FAIL restart: start=%b idx=%0d epoch=%0d active=%b expected 1 0 0 1",
               eng_start, eng_sample_idx, current_epoch, training_active);
    end
    train_req = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (current_epoch !== 8'd0 || current_sample !== 5'd2) begin
      errors++;
      $display("FAIL restart_prog: epoch=%0d sample=%0d expected 0 2",
               current_epoch, current_sample);
    end
  endtask

  task automatic test_timeout();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    eng_en = 1'b0;
    @(negedge clk) infer_req = 1'b1;
    @(negedge clk);
    infer_req = 1'b0;
    checks++;
    if (eng_start !== 1'b1) begin
      errors++;
      $display("FAIL to_issue: start=%b expected 1", eng_start);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_early: err=%b expected 0", timeout_err);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_infer: err=%b rv=%b expected 1 0", timeout_err, result_valid);
    end
    @(negedge clk) train_req = 1'b1;
    @(negedge clk);
    train_req = 1'b0;
    checks++;
    if (eng_start !== 1'b1 || timeout_err !== 1'b0 || training_active !== 1'b1) begin
      errors++;
      $display("FAIL to_train_issue: start=%b err=%b active=%b expected 1 0 1",
               eng_start, timeout_err, training_active);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (training_active !== 1'b1) begin
      errors++;
      $display("FAIL to_train_early: active=%b expected 1", training_active);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || training_active !== 1'b0 || training_done !== 1'b0) begin
      errors++;
      $display("FAIL to_train: err=%b active=%b done=%b expected 1 0 0",
               timeout_err, training_active, training_done);
    end
    eng_en = 1'b1;
    ey = 1'b1;
    ep = 7'd50;
    @(negedge clk) infer_req = 1'b1;
    for (int i = 0; i < 20 && !result_valid; i++) @(negedge clk);
    infer_req = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || result_prob !== 7'd50 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_recover: rv=%b p=%0d err=%b expected 1 50 1",
               result_valid, result_prob, timeout_err);
    end
  endtask

  initial begin
    test_reset();
    test_train_full();
    test_infer();
    test_simultaneous();
    test_busy_requests();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
